// File: rtl/dc_token_ring_fifo_dout_if.sv
// Bundle of signals between the read half of the dual-clock token-ring FIFO,
// its consumer stream and the producer-side data buffer.
interface dc_token_ring_fifo_dout_if #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 8
);
    logic [DATA_WIDTH-1:0]   data;
    logic                    valid;
    logic                    ready;
    logic [BUFFER_DEPTH-1:0] read_pointer;
    logic [BUFFER_DEPTH-1:0] write_token;
    logic [DATA_WIDTH-1:0]   data_async;

    // master is the FIFO read side, slave is the consumer plus producer buffer
    modport master (
        output data, valid, read_pointer,
        input  ready, write_token, data_async
    );

    modport slave (
        input  data, valid, read_pointer,
        output ready, write_token, data_async
    );
endinterface

// File: rtl/dc_token_ring_fifo_dout.sv
// Consumer-domain half of the dual-clock token-ring FIFO: synchronizes the
// producer's two-hot write token, tracks its own read token and registers output.
module dc_token_ring_fifo_dout #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    dc_token_ring_fifo_dout_if.master     bus
);

    localparam logic [BUFFER_DEPTH-1:0] TOKEN_RESET = BUFFER_DEPTH'('hC);

    logic [BUFFER_DEPTH-1:0] sync_stage;
    logic [BUFFER_DEPTH-1:0] sync_token;
    logic [BUFFER_DEPTH-1:0] read_token;
    logic [BUFFER_DEPTH-1:0] sync_write_pointer;
    logic [BUFFER_DEPTH-1:0] read_slot;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    empty;
    logic                    fetch;

    // A two-hot token points at the upper bit of its adjacent pair.
    function automatic logic [BUFFER_DEPTH-1:0] ptr(input logic [BUFFER_DEPTH-1:0] t);
        return {t[BUFFER_DEPTH-2:0], t[BUFFER_DEPTH-1]} & t;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_stage <= TOKEN_RESET;
            sync_token <= TOKEN_RESET;
        end else begin
            sync_stage <= bus.write_token;
            sync_token <= sync_stage;
        end
    end

    assign sync_write_pointer = ptr(sync_token);
    assign read_slot          = ptr(read_token);

    // Skewed tokens decoding to zero bits or two bits both resolve safely here.
    assign empty = |(read_slot & sync_write_pointer);
    assign fetch = ~empty & (~valid_q | bus.ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            read_token <= TOKEN_RESET;
        end else if (fetch) begin
            read_token <= {read_token[BUFFER_DEPTH-2:0], read_token[BUFFER_DEPTH-1]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (fetch) begin
            data_q  <= bus.data_async;
            valid_q <= 1'b1;
        end else if (valid_q && bus.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.data         = data_q;
    assign bus.valid        = valid_q;
    assign bus.read_pointer = read_slot;

endmodule

// File: tb/tb_dc_token_ring_fifo_dout.sv
// Bench for the FIFO read half: a behavioural producer buffer drives the DUT
// and a word queue predicts ordering, latency and read slot position.
module tb_dc_token_ring_fifo_dout;

    localparam int DW = 10;
    localparam int D  = 8;

    logic clk;
    logic rstn;

    dc_token_ring_fifo_dout_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) bus ();

    dc_token_ring_fifo_dout #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] buffer [D];
    logic [D-1:0]  wtok;
    int            wslot;
    logic [DW-1:0] exp_q[$];
    int            exp_t[$];
    int            transfers;
    int            cyc;
    int            first_xfer;
    int            last_xfer;
    int            checks;
    int            failures;

    function automatic int onehot_idx(input logic [D-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < D; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [D-1:0] slot_onehot(input int s);
        logic [D-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    // The buffer is read combinationally at whichever slot the DUT selects.
    always_comb bus.data_async = buffer[onehot_idx(bus.read_pointer)];

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // A word written three cycles ago must be presented; nothing may appear
    // without an outstanding word; the read slot counts every fetched word.
    task automatic check_output();
        int fetched;
        fetched = transfers + ((bus.valid === 1'b1) ? 1 : 0);
        if (exp_q.size() == 0)
            check_eq("valid_idle", 32'(bus.valid), 32'(0));
        else if (cyc - exp_t[0] >= 3)
            check_eq("valid_due", 32'(bus.valid), 32'(1));
        if (bus.valid === 1'b1 && exp_q.size() > 0)
            check_eq("data_order", 32'(bus.data), 32'(exp_q[0]));
        check_eq("read_pointer", 32'(bus.read_pointer), 32'(slot_onehot((3 + fetched) % D)));
    endtask

    task automatic apply_stimulus(input bit do_write, input logic [DW-1:0] wdata, input bit rdy);
        bus.ready = rdy;
        if (bus.valid === 1'b1 && rdy && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
            transfers++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        if (do_write) begin
            buffer[wslot]   = wdata;
            wtok            = {wtok[D-2:0], wtok[D-1]};
            wslot           = (wslot + 1) % D;
            bus.write_token = wtok;
            exp_q.push_back(wdata);
            exp_t.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
        check_output();
    endtask

    task automatic reset_model();
        wtok            = D'('hC);
        bus.write_token = wtok;
        wslot           = 3;
        exp_q.delete();
        exp_t.delete();
        transfers       = 0;
    endtask

    initial begin
        int            base;
        logic [D-1:0]  rp_hold;
        logic [DW-1:0] rw;
        bit            wr;
        bit            rd;

        checks     = 0;
        failures   = 0;
        cyc        = 0;
        first_xfer = -1;
        last_xfer  = -1;
        for (int i = 0; i < D; i++) buffer[i] = '0;
        rstn      = 1'b0;
        bus.ready = 1'b0;
        reset_model();

        #12;
        check_eq("reset_valid", 32'(bus.valid), 32'(0));
        check_eq("reset_data", 32'(bus.data), 32'(0));
        check_eq("reset_rp", 32'(bus.read_pointer), 32'('h08));
        @(negedge clk);
        rstn = 1'b1;

        // single word, exact three-edge latency
        apply_stimulus(1'b1, DW'('h2A5), 1'b0);
        apply_stimulus(1'b0, '0, 1'b0);
        check_eq("latency_early", 32'(bus.valid), 32'(0));
        apply_stimulus(1'b0, '0, 1'b0);
        check_eq("single_valid", 32'(bus.valid), 32'(1));
        check_eq("single_data", 32'(bus.data), 32'('h2A5));
        apply_stimulus(1'b0, '0, 1'b1);
        check_eq("single_rp", 32'(bus.read_pointer), 32'('h10));
        check_eq("single_drop", 32'(bus.valid), 32'(0));

        // burst of 20 with wrap
        base       = transfers;
        first_xfer = -1;
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, DW'(i), 1'b1);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) apply_stimulus(1'b0, '0, 1'b1);
        check_eq("burst_drained", 32'(exp_q.size()), 32'(0));
        check_eq("burst_count", 32'(transfers - base), 32'(20));
        check_eq("burst_rate", 32'(last_xfer - first_xfer), 32'(19));

        // backpressure
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, DW'('h100 + i), 1'b0);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, '0, 1'b0);
        check_eq("bp_valid", 32'(bus.valid), 32'(1));
        check_eq("bp_data", 32'(bus.data), 32'('h100));
        base = transfers;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b1);
        check_eq("bp_count", 32'(transfers - base), 32'(4));
        check_eq("bp_drained", 32'(exp_q.size()), 32'(0));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            wr = ($urandom_range(0, 1) == 1) && (exp_q.size() < 6);
            rd = ($urandom_range(0, 3) != 0);
            rw = DW'($urandom_range(0, (1 << DW) - 1));
            apply_stimulus(wr, rw, rd);
        end
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) apply_stimulus(1'b0, '0, 1'b1);
        check_eq("rand_drained", 32'(exp_q.size()), 32'(0));

        // empty hold
        rp_hold = bus.read_pointer;
        for (int i = 0; i < 50; i++) apply_stimulus(1'b0, '0, bit'(i % 2));
        check_eq("empty_rp_hold", 32'(bus.read_pointer), 32'(rp_hold));

        // reset mid-stream
        apply_stimulus(1'b1, DW'('h3C3), 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b0);
        check_eq("pre_reset_valid", 32'(bus.valid), 32'(1));
        #2;
        rstn = 1'b0;
        reset_model();
        #1;
        check_eq("mid_reset_valid", 32'(bus.valid), 32'(0));
        check_eq("mid_reset_data", 32'(bus.data), 32'(0));
        check_eq("mid_reset_rp", 32'(bus.read_pointer), 32'('h08));
        @(negedge clk);
        cyc++;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, '0, 1'b1);

        // token skew with the reader at slot 4
        apply_stimulus(1'b1, DW'('h0AA), 1'b0);
        for (int i = 0; i < 2; i++) apply_stimulus(1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1);
        check_eq("skew_setup_rp", 32'(bus.read_pointer), 32'('h10));
        bus.write_token = D'('h38);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, '0, 1'b1);
        check_eq("skew3_no_fetch", 32'(bus.read_pointer), 32'('h10));
        buffer[4] = DW'('h155);
        exp_q.push_back(DW'('h155));
        exp_t.push_back(cyc);
        bus.write_token = D'('h10);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b0);
        check_eq("skew1_valid", 32'(bus.valid), 32'(1));
        check_eq("skew1_data", 32'(bus.data), 32'('h155));
        check_eq("skew1_rp", 32'(bus.read_pointer), 32'('h20));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
